ascii_packer: RTL

Serial-to-parallel ASCII encoder. Accepts one 8-bit character per valid/ready handshake and packs the characters into a NUM_CHARS-byte word. The first character received goes in the most-significant byte, so byte 0 is data[8*NUM_CHARS-1 -: 8]. A downstream ASCII word decoder consumes the packed word and renders it from the top byte down.

---
 rtl/ascii_packer_if.sv | 25 ++
 rtl/ascii_packer.sv | 84 ++++++++
 2 files changed

// File: rtl/ascii_packer_if.sv
// Character-in / packed-word-out handshake bundle for ascii_packer.
interface ascii_packer_if #(
  parameter int unsigned NUM_CHARS = 24,
  parameter int unsigned CNT_W     = 5
);
  logic                   in_valid;
  logic                   in_ready;
  logic [7:0]             in_char;
  logic                   in_last;
  logic                   out_valid;
  logic                   out_ready;
  logic [8*NUM_CHARS-1:0] out_data;
  logic [CNT_W-1:0]       out_count;
  logic                   err_non_ascii;

  modport master (
    output in_valid, in_char, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_count, err_non_ascii
  );

  modport slave (
    input  in_valid, in_char, in_last, out_ready,
    output in_ready, out_valid, out_data, out_count, err_non_ascii
  );
endinterface

// File: rtl/ascii_packer.sv
// Packs accepted 7-bit ASCII bytes into a NUM_CHARS-byte word, first byte in the MSBs,
// unused positions filled with PAD_CHAR; non-ASCII bytes are dropped with an error pulse.
module ascii_packer #(
  parameter int unsigned NUM_CHARS = 24,
  parameter logic [7:0]  PAD_CHAR  = 8'h20,
  parameter int unsigned CNT_W     = 5
) (
  input logic          clk,
  input logic          rst_n,
  ascii_packer_if.slave bus
);
  typedef enum logic {FILL, HOLD} state_t;

  state_t                 state, state_n;
  logic [CNT_W-1:0]       idx, idx_n;
  logic [CNT_W-1:0]       count, count_n;
  logic [8*NUM_CHARS-1:0] data, data_n;
  logic                   err, err_n;
  logic [CNT_W-1:0]       idx_inc;

  assign idx_inc = idx + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FILL;
      idx   <= '0;
      count <= '0;
      data  <= {NUM_CHARS{PAD_CHAR}};
      err   <= 1'b0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      count <= count_n;
      data  <= data_n;
      err   <= err_n;
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    count_n = count;
    data_n  = data;
    err_n   = 1'b0;
    unique case (state)
      FILL: begin
        if (bus.in_valid) begin
          if (bus.in_char[7]) begin
            // Dropped byte still closes the word if it carries in_last.
            err_n = 1'b1;
            if (bus.in_last) begin
              state_n = HOLD;
              count_n = idx;
            end
          end else begin
            for (int unsigned i = 0; i < NUM_CHARS; i++) begin
              if (CNT_W'(i) == idx) data_n[8*(NUM_CHARS-1-i) +: 8] = bus.in_char;
            end
            idx_n = idx_inc;
            if (bus.in_last || idx_inc == CNT_W'(NUM_CHARS)) begin
              state_n = HOLD;
              count_n = idx_inc;
            end
          end
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          state_n = FILL;
          idx_n   = '0;
          count_n = '0;
          data_n  = {NUM_CHARS{PAD_CHAR}};
        end
      end
      default: state_n = FILL;
    endcase
  end

  assign bus.in_ready      = (state == FILL);
  assign bus.out_valid     = (state == HOLD);
  assign bus.out_data      = data;
  assign bus.out_count     = count;
  assign bus.err_non_ascii = err;
endmodule
